// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that gives one requester at a time the beat stream into a UART TX controller.
// Define UART_TX_ARB_TIMEOUT_EN to revoke grants held too long by an owner with no valid beat.
module uart_tx_arb #(
    parameter int DLY        = 1,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_vld_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_vld_o,
    input  logic                          tx_rdy_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // DLY is kept for interface compatibility; registers update with no modelled delay.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535 || DLY < 0) begin : g_param_chk
        $error("uart_tx_arb: parameter out of range");
    end

    logic [0:0]            state_q, state_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      cand;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic                  in_grant;
    logic                  own_vld;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  xfer;
    logic                  to_hit;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(NUM_REQ - 1)) ? '0 : i + PTR_W'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr_q;
        cand     = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && req_vld_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
            cand = nxt(cand);
        end
    end

    always_comb begin
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == PTR_W'(k)) begin
                own_vld  = req_vld_i[k];
                own_last = req_last_i[k];
                own_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_grant  = (state_q == GRANT);
    assign busy_o    = in_grant;
    assign tx_vld_o  = in_grant & own_vld;
    assign tx_data_o = in_grant ? own_data : '0;
    assign xfer      = tx_vld_o & tx_rdy_i;

    always_comb begin
        req_rdy_o = '0;
        grant_o   = '0;
        if (in_grant) begin
            req_rdy_o[owner_q] = tx_rdy_i;
            grant_o[owner_q]   = 1'b1;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    // Counts consecutive owner cycles with no valid beat; any valid beat restarts it.
    always_comb begin
        to_cnt_d = '0;
        to_hit   = 1'b0;
        if (in_grant && !own_vld) begin
            if (to_cnt_q == 16'(TIMEOUT - 1)) begin
                to_hit = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end
        timeout_d = to_hit;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                end
            end
            GRANT: begin
                if ((xfer && own_last) || to_hit) begin
                    state_d  = IDLE;
                    rr_ptr_d = nxt(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
